// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
package fetch_pkg;
    localparam int DEF_PC_WIDTH    = 16;
    localparam int DEF_INSTR_WIDTH = 16;
    localparam logic [3:0] HALT_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two synchronous FIFO; clear beats push, head reads 0 when empty.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end

    assign dout = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, fetch FSM and redirect handling feeding a {pc, instr} skid FIFO.
// Optional HALT-opcode stop is enabled by defining FETCH_HALT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   fetch_en,
    output logic [PC_WIDTH-1:0]    imem_pc,
    input  logic [INSTR_WIDTH-1:0] imem_instr,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic                   halted
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    state_t state, state_nx;
    logic [PC_WIDTH-1:0] pc;
    logic [CW-1:0]       count;
    logic                fetch;
    logic                pop;
    logic                halt_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (redirect_valid) state_nx = fetch_en ? S_RUN : S_IDLE;
        else if (state == S_IDLE) state_nx = fetch_en ? S_RUN : S_IDLE;
        else if (state == S_RUN) state_nx = !fetch_en ? S_IDLE : halt_hit ? S_HALTED : S_RUN;
    end

    // Fetch is judged on pre-pop occupancy, so a full FIFO never pushes even while popping.
    always_comb begin
        fetch = state == S_RUN && fetch_en && count < FULL && !redirect_valid;
`ifdef FETCH_HALT_EN
        halt_hit = fetch && imem_instr[INSTR_WIDTH-1 -: 4] == HALT_OPCODE;
        halted   = state == S_HALTED;
`else
        halt_hit = 1'b0;
        halted   = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pc <= RESET_PC;
        else pc <= redirect_valid ? redirect_pc : fetch ? pc + PC_WIDTH'(1) : pc;
    end

    assign imem_pc   = pc;
    assign out_valid = count != '0;
    assign pop       = out_valid && out_ready;

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(PC_WIDTH + INSTR_WIDTH)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (redirect_valid),
        .push   (fetch),
        .pop    (pop),
        .din    ({pc, imem_instr}),
        .count  (count),
        .dout   ({out_pc, out_instr})
    );
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 16-bit RISC core.
- Owns the program counter and drives it to the combinational instruction ROM.
- Captures the returned instruction word together with its PC into a small skid FIFO.
- Presents {pc, instr} to the decode stage with a valid/ready handshake; accepts branch/jump redirects from execute, which flush the FIFO.

Parameters:
- PC_WIDTH, 16, program counter width; word-addressed, one instruction per address.
- INSTR_WIDTH, 16, instruction word width.
- RESET_PC, 16'h0000, PC value loaded on reset.
- FIFO_DEPTH, 2, entries in the fetch FIFO; power of two, >= 2.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- fetch_en  in  1  high = fetching permitted; low = PC holds, FIFO drains
- imem_pc  out  PC_WIDTH  address to instruction ROM; equals the internal PC register
- imem_instr  in  INSTR_WIDTH  combinational ROM read data for imem_pc
- redirect_valid  in  1  one-cycle pulse: load new PC and flush
- redirect_pc  in  PC_WIDTH  target PC for redirect
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decode accepts head this cycle
- out_pc  out  PC_WIDTH  PC of head instruction
- out_instr  out  INSTR_WIDTH  head instruction word
- halted  out  1  fetch stopped on HALT opcode (see Optional Feature)

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - pc = RESET_PC, FIFO count = 0, state = S_IDLE.
  - out_valid = 0, out_pc = 0, out_instr = 0, halted = 0.
- FSM states:
  - S_IDLE: no fetch. Goes to S_RUN when fetch_en = 1.
  - S_RUN: fetches. Goes to S_IDLE when fetch_en = 0 (checked each cycle); goes to S_HALTED only with the optional feature.
- Fetch condition: state == S_RUN && fetch_en && count < FIFO_DEPTH && !redirect_valid.
  - On fetch: push {pc, imem_instr}, then pc <= pc + 1.
  - The fetch condition is evaluated on pre-pop count. A full FIFO with a simultaneous pop does not push; that costs one bubble only under backpressure.
- Pop: out_valid && out_ready. out_pc/out_instr always reflect the FIFO head; both are 0 when empty.
- Latency:
  - pc presented in cycle N appears at out_* in cycle N+1.
  - With out_ready held high there is one instruction per cycle and no bubbles.
- Simultaneous push and pop with count < FIFO_DEPTH: count unchanged, order preserved.
- Redirect (highest priority, any state):
  - pc <= redirect_pc; FIFO cleared (count = 0); no push that cycle; out_valid = 0 next cycle.
  - A pop in the same cycle is discarded.
  - Next state is S_RUN if fetch_en, else S_IDLE; a redirect also leaves S_HALTED.
  - First redirected instruction appears at out_* two cycles after the redirect pulse.
- PC wrap: pc increments modulo 2^PC_WIDTH; 16'hFFFF + 1 = 16'h0000. The ROM applies its own address wrap.
- fetch_en low mid-stream: PC holds at the next unfetched address; existing entries still drain through the handshake.
- Reset mid-operation: all state returns to reset values immediately; in-flight FIFO contents are lost.
- out_* must remain stable while out_valid && !out_ready.

Optional Feature:
- Macro FETCH_HALT_EN.
- Defined:
  - A pushed instruction with instr[15:12] == HALT_OPCODE (4'hF) moves the FSM to S_HALTED after the push.
  - In S_HALTED, halted = 1 and no further fetch occurs. The HALT word itself is delivered downstream; the PC points past it.
  - Only redirect_valid or reset leaves S_HALTED; redirect returns halted to 0 next cycle.
- Undefined: S_HALTED does not exist, halted is tied to 0, and the HALT opcode is fetched like any other.

Decomposition:
- Shared package fetch_pkg:
  - state enum (S_IDLE, S_RUN, S_HALTED)
  - HALT_OPCODE
  - PC_WIDTH and INSTR_WIDTH defaults
- One sub-module, fetch_fifo:
  - parameterised depth/width synchronous FIFO with push, pop, clear, count, head data.
  - clear has priority over push.
- fetch_unit holds the PC, the FSM and the redirect logic.

Test Plan:
- Reset, then fetch_en = 1, out_ready = 1, ROM[i] = 16'h1000 + i -> out_valid rises one cycle after entering S_RUN; out_pc 0,1,2,3 with out_instr 16'h1000..16'h1003 on consecutive cycles.
- out_ready = 0 for 5 cycles mid-stream -> count saturates at 2, imem_pc holds, out_* stable; on release the sequence continues with no loss or duplication.
- redirect_valid pulse with redirect_pc = 16'h0040 while FIFO is full -> next cycle out_valid = 0; two cycles after the pulse out_pc = 16'h0040, out_instr = ROM[0x40].
- pc preloaded via redirect to 16'hFFFE -> out_pc sequence FFFE, FFFF, 0000.
- reset_n asserted asynchronously mid-cycle during traffic -> out_valid = 0 and imem_pc = RESET_PC immediately, without waiting for a clock edge.
- FETCH_HALT_EN defined, ROM[3] = 16'hF000 -> instructions 0..3 delivered, halted = 1, imem_pc stays 4; a redirect to 0 clears halted and restarts fetch.
